// File: rtl/hazard_unit_if.sv
// Bundle of pipeline-side signals exchanged with the hazard unit.
// The pipeline (master) drives register indices and stage status; the hazard unit (slave) returns selects and stall/flush controls.
interface hazard_unit_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [4:0]       RdM;
  logic [4:0]       RdW;
  logic             PCSrcE;
  logic             ResultSrcb0E;
  logic             RegWriteM;
  logic             RegWriteW;
  logic             MemReqM;
  logic             MemReadyM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCycles;
  logic             dbg_wait;

  // Memory handshake: an access is pending while MemReqM=1 and completes in the
  // cycle MemReadyM=1 is seen alongside it; MemReqM=0 means no access, MemReadyM ignored.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output PCSrcE, ResultSrcb0E, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemTimeout, StallCycles, dbg_wait
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  PCSrcE, ResultSrcb0E, RegWriteM, RegWriteW, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemTimeout, StallCycles, dbg_wait
  );
endinterface

// File: rtl/hazard_unit.sv
// Forwarding, load-use stall, branch flush and memory-wait control for the 5-stage pipeline.
// Also tracks a sticky memory-wait timeout and a saturating count of fetch-stall cycles.
module hazard_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_unit_if.slave hz
);
  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t           state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic lw_stall;
  logic mem_stall;
  logic stall_f;

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
      hz.ForwardAE = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
      hz.ForwardAE = 2'b01;

    hz.ForwardBE = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
      hz.ForwardBE = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
      hz.ForwardBE = 2'b01;
  end

  assign lw_stall  = hz.ResultSrcb0E && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_stall = hz.MemReqM && !hz.MemReadyM;
  assign stall_f   = lw_stall || mem_stall;

  // A memory wait freezes everything up to M, so a taken branch stays parked
  // in E and its flush is deferred to the cycle the wait ends.
  assign hz.StallF = stall_f;
  assign hz.StallD = stall_f;
  assign hz.StallE = mem_stall;
  assign hz.StallM = mem_stall;
  assign hz.FlushW = mem_stall;
  assign hz.FlushD = hz.PCSrcE && !mem_stall;
  assign hz.FlushE = (lw_stall || hz.PCSrcE) && !mem_stall;

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    stall_cycles_d = stall_cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          // Counter parks at TIMEOUT; the wait is never forcibly released.
          if (wait_cnt_q == WCNT_MAX) mem_timeout_d = 1'b1;
          else                        wait_cnt_d    = wait_cnt_q + WCNT_W'(1);
        end else begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
      end
    endcase

    if (stall_f && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hz.MemTimeout  = mem_timeout_q;
  assign hz.StallCycles = stall_cycles_q;
  assign hz.dbg_wait    = (state_q == ST_WAIT);
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with hand-computed expectations (TIMEOUT=4, CNT_W=4).
module tb_hazard_unit;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];

  hazard_unit_if #(.CNT_W(CNT_W)) hz ();

  hazard_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    hz.PCSrcE = 1'b0; hz.ResultSrcb0E = 1'b0;
    hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hz.ResultSrcb0E = 1'b1; hz.RdE = rd; hz.Rs2D = 5'd7; hz.Rs1D = 5'd3;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // reset state
    check("rst_timeout", 32'(hz.MemTimeout), 0);
    check("rst_cnt", 32'(hz.StallCycles), 0);
    check("rst_state", 32'(hz.dbg_wait), 0);

    // forwarding
    hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1;
    #1 check("fwdA_m_prio", 32'(hz.ForwardAE), 2);
    hz.RdM = 5'd0;
    #1 check("fwdA_w_rdm0", 32'(hz.ForwardAE), 1);
    hz.Rs2E = 5'd0; hz.RdW = 5'd0;
    #1 check("fwdB_none", 32'(hz.ForwardBE), 0);
    hz.Rs2E = 5'd9; hz.RdM = 5'd9; hz.RegWriteM = 1'b1;
    #1 check("fwdB_m", 32'(hz.ForwardBE), 2);
    hz.RegWriteM = 1'b0; hz.RdW = 5'd9;
    #1 check("fwdB_w", 32'(hz.ForwardBE), 1);
    hz.RegWriteW = 1'b0;
    #1 check("fwdB_w_nowrite", 32'(hz.ForwardBE), 0);
    idle_inputs();

    // load-use stall
    set_load_use(5'd7);
    #1;
    check("lw_stallF", 32'(hz.StallF), 1);
    check("lw_stallD", 32'(hz.StallD), 1);
    check("lw_flushE", 32'(hz.FlushE), 1);
    check("lw_stallE", 32'(hz.StallE), 0);
    step();
    idle_inputs();
    check("lw_cnt", 32'(hz.StallCycles), 1);
    set_load_use(5'd0);
    #1 check("lw_rd0_nostall", 32'(hz.StallF), 0);
    step();
    idle_inputs();
    check("lw_cnt_hold", 32'(hz.StallCycles), 1);

    // branch flush, deferred by a memory wait
    hz.PCSrcE = 1'b1;
    #1;
    check("br_flushD", 32'(hz.FlushD), 1);
    check("br_flushE", 32'(hz.FlushE), 1);
    check("br_stallF", 32'(hz.StallF), 0);
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("brw_flushD", 32'(hz.FlushD), 0);
      check("brw_flushE", 32'(hz.FlushE), 0);
      check("brw_stallE", 32'(hz.StallE), 1);
      check("brw_stallM", 32'(hz.StallM), 1);
      check("brw_flushW", 32'(hz.FlushW), 1);
      step();
      check("brw_state", 32'(hz.dbg_wait), 1);
    end
    hz.MemReadyM = 1'b1;
    #1;
    check("brr_flushD", 32'(hz.FlushD), 1);
    check("brr_flushE", 32'(hz.FlushE), 1);
    check("brr_stallF", 32'(hz.StallF), 0);
    check("brr_stallE", 32'(hz.StallE), 0);
    step();
    check("brr_state", 32'(hz.dbg_wait), 0);
    check("brr_cnt", 32'(hz.StallCycles), 4);
    idle_inputs();

    // load-use together with a taken branch
    set_load_use(5'd7);
    hz.PCSrcE = 1'b1;
    #1;
    check("lwbr_flushD", 32'(hz.FlushD), 1);
    check("lwbr_flushE", 32'(hz.FlushE), 1);
    check("lwbr_stallF", 32'(hz.StallF), 1);
    idle_inputs();

    // wait timeout
    do_reset();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    for (int k = 1; k <= TIMEOUT + 2; k++) exp_q.push_back((k >= 5) ? 32'd1 : 32'd0);
    for (int k = 1; k <= TIMEOUT + 2; k++) begin
      step();
      check($sformatf("tmo_edge%0d", k), 32'(hz.MemTimeout), exp_q.pop_front());
    end
    check("tmo_cnt", 32'(hz.StallCycles), 6);
    hz.MemReadyM = 1'b1;
    step();
    check("tmo_sticky", 32'(hz.MemTimeout), 1);
    check("tmo_idle", 32'(hz.dbg_wait), 0);
    hz.MemReqM = 1'b0;
    step();
    check("tmo_sticky2", 32'(hz.MemTimeout), 1);
    do_reset();
    check("tmo_rst", 32'(hz.MemTimeout), 0);

    // reset while waiting
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    step();
    step();
    check("rw_inwait", 32'(hz.dbg_wait), 1);
    check("rw_cnt", 32'(hz.StallCycles), 2);
    reset = 1'b1;
    step();
    check("rw_state", 32'(hz.dbg_wait), 0);
    check("rw_cnt0", 32'(hz.StallCycles), 0);
    check("rw_tmo0", 32'(hz.MemTimeout), 0);
    reset = 1'b0;
    idle_inputs();
    step();

    // counter saturation
    do_reset();
    set_load_use(5'd7);
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat_%0d", i), 32'(hz.StallCycles), (i > 15) ? 32'd15 : 32'(i));
    end
    idle_inputs();
    step();
    check("sat_hold", 32'(hz.StallCycles), 15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
